// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
//  Module   : plic_gateway
//  Purpose  : Per-source PLIC interrupt gateway. Synchronizes raw interrupt
//             lines, turns level or rising-edge requests into one pending bit
//             per source and tracks claim/complete so each source has at most
//             one outstanding request. Edges arriving while a request is
//             outstanding are counted (saturating) and replayed later.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in  1         rising-edge clock
//    rst            in  1         asynchronous active-high reset
//    irq_src        in  NUM_SRC   raw asynchronous interrupt lines
//    edge_sel       in  NUM_SRC   1 = rising-edge mode, 0 = level mode
//    claim_valid    in  1         one-cycle claim strobe
//    claim_id       in  ID_WIDTH  source ID being claimed (1..NUM_SRC)
//    complete_valid in  1         one-cycle completion strobe
//    complete_id    in  ID_WIDTH  source ID being completed (1..NUM_SRC)
//    pending        out NUM_SRC   source is PENDING
//    in_service     out NUM_SRC   source is CLAIMED
//    edge_drop      out NUM_SRC   one-cycle pulse: edge lost at saturation
// ============================================================================
module plic_gateway #(
    parameter int NUM_SRC  = 7,
    parameter int ID_WIDTH = 3,
    parameter int MAX_EDGE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic [NUM_SRC-1:0]  edge_sel,
    input  logic                claim_valid,
    input  logic [ID_WIDTH-1:0] claim_id,
    input  logic                complete_valid,
    input  logic [ID_WIDTH-1:0] complete_id,
    output logic [NUM_SRC-1:0]  pending,
    output logic [NUM_SRC-1:0]  in_service,
    output logic [NUM_SRC-1:0]  edge_drop
);

    localparam int CNT_W = $clog2(MAX_EDGE + 1);

    // State encoding chosen so that pending/in_service are direct flop bits.
    localparam logic [1:0] C_IDLE    = 2'b00;
    localparam logic [1:0] C_PENDING = 2'b01;
    localparam logic [1:0] C_CLAIMED = 2'b10;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_EDGE);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    // Two-flop synchronizer (r_sync2 is the synchronized level) plus a delay
    // flop for rising-edge detection.
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync1  <= irq_src;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_drop;
        logic             w_drop_nxt;
        logic             w_rise;
        logic             w_claim_hit;
        logic             w_complete_hit;

        assign w_rise = r_sync2[i] & ~r_sync_d[i];

        // IDs 0 and > NUM_SRC never match any source, so they are ignored.
        assign w_claim_hit    = claim_valid    && (claim_id    == ID_WIDTH'(i + 1));
        assign w_complete_hit = complete_valid && (complete_id == ID_WIDTH'(i + 1));

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_drop_nxt  = 1'b0;

            case (r_state)
                C_IDLE: begin
                    if (edge_sel[i]) begin
                        // A fresh edge takes priority; a stored edge is only
                        // consumed when no new edge is present.
                        if (w_rise) begin
                            w_state_nxt = C_PENDING;
                        end else if (r_cnt != '0) begin
                            w_state_nxt = C_PENDING;
                            w_cnt_nxt   = r_cnt - C_CNT_ONE;
                        end
                    end else if (r_sync2[i]) begin
                        w_state_nxt = C_PENDING;
                    end
                end
                C_PENDING: begin
                    if (w_claim_hit) begin
                        w_state_nxt = C_CLAIMED;
                    end
                end
                C_CLAIMED: begin
                    if (w_complete_hit) begin
                        w_state_nxt = C_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = C_IDLE;
                end
            endcase

            // Edges seen while a request is outstanding are banked.
            if (edge_sel[i] && w_rise && (r_state != C_IDLE)) begin
                if (r_cnt == C_CNT_MAX) begin
                    w_drop_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            if (!edge_sel[i]) begin
                w_cnt_nxt = '0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= C_IDLE;
                r_cnt   <= '0;
                r_drop  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_drop  <= w_drop_nxt;
            end
        end

        assign pending[i]    = r_state[0];
        assign in_service[i] = r_state[1];
        assign edge_drop[i]  = r_drop;
    end

endmodule
`default_nettype wire
